// File: rtl/rvh_noc_pkg.sv
// Shared NoC router definitions used by the switch-allocation blocks.
//   VC_ID_NUM_MAX_W  : width of a binary VC id
//   QoS_Value_Width  : width of a per-VC QoS value
//   sa_local_state_e : local allocator hold state (IDLE / HOLD)
package rvh_noc_pkg;

    localparam int unsigned VC_ID_NUM_MAX_W = 3;
    localparam int unsigned QoS_Value_Width = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sa_local_state_e;

endpackage

// File: rtl/sa_local_vc_pick.sv
// Combinational VC picker for the local switch allocator.
// Keeps only eligible VCs whose effective QoS equals the maximum among
// eligible VCs. Then it picks the lowest such index at or above rr_ptr,
// wrapping around to index 0.
//   elig     : per-VC eligibility
//   eq       : per-VC effective QoS
//   rr_ptr   : round-robin start index (0..VC_NUM-1)
//   pick_vld : some VC was picked
//   pick_oh  : one-hot of the picked VC
//   pick_id  : binary id of the picked VC
module sa_local_vc_pick
    import rvh_noc_pkg::*;
#(
    parameter int unsigned VC_NUM  = 6,
    parameter int unsigned VC_ID_W = VC_ID_NUM_MAX_W,
    parameter int unsigned QOS_W   = QoS_Value_Width
) (
    input  logic [VC_NUM-1:0]            elig,
    input  logic [VC_NUM-1:0][QOS_W-1:0] eq,
    input  logic [VC_ID_W-1:0]           rr_ptr,
    output logic                         pick_vld,
    output logic [VC_NUM-1:0]            pick_oh,
    output logic [VC_ID_W-1:0]           pick_id
);

    logic [QOS_W-1:0]    max_q;
    logic [VC_NUM-1:0]   cand;
    logic [2*VC_NUM-1:0] dbl;
    logic [2*VC_NUM-1:0] masked;
    logic                found;
    int unsigned         idx;

    always_comb begin
        max_q = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            if (elig[v] && (eq[v] > max_q)) begin
                max_q = eq[v];
            end
        end
    end

    always_comb begin
        cand = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            cand[v] = elig[v] && (eq[v] == max_q);
        end
    end

    // The lower copy only supplies candidates at or above rr_ptr. The upper
    // copy supplies the wrapped candidates. Then a priority search runs
    // from bit 0 upward.
    always_comb begin
        dbl    = {cand, cand};
        masked = '0;
        for (int unsigned i = 0; i < 2 * VC_NUM; i++) begin
            masked[i] = dbl[i] && (i >= 32'(rr_ptr));
        end
    end

    always_comb begin
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < 2 * VC_NUM; i++) begin
            if (masked[i] && !found) begin
                found = 1'b1;
                idx   = (i >= VC_NUM) ? (i - VC_NUM) : i;
            end
        end
    end

    always_comb begin
        pick_vld = |cand;
        pick_oh  = '0;
        pick_id  = '0;
        if (found) begin
            pick_oh = VC_NUM'(1) << idx;
            pick_id = VC_ID_W'(idx);
        end
    end

endmodule

// File: rtl/sa_local.sv
// Per-input-port local switch allocator.
// Each cycle it presents one eligible VC to the global switch allocator: a VC
// that has a head flit and downstream credit. The pick is held stable until the
// global stage grants this port. Starved VCs age up to maximum QoS.
//   clk, rst              : clock, synchronous active-high reset
//   vc_head_vld_i         : per-VC head flit ready
//   vc_credit_ok_i        : per-VC downstream credit available
//   vc_qos_value_i        : per-VC QoS, VC v at [v*QOS_W +: QOS_W]
//   sa_global_grt_i       : global stage granted this port
//   sa_local_vld_o        : a VC is presented
//   sa_local_vc_id_o      : binary id of the presented VC
//   sa_local_vc_oh_o      : one-hot of the presented VC
//   sa_local_qos_value_o  : effective QoS of the presented VC
module sa_local
    import rvh_noc_pkg::*;
#(
    parameter int unsigned VC_NUM        = 6,
    parameter int unsigned VC_ID_W       = VC_ID_NUM_MAX_W,
    parameter int unsigned QOS_W         = QoS_Value_Width,
    parameter int unsigned AGE_THRESHOLD = 15,
    parameter int unsigned AGE_W         = $clog2(AGE_THRESHOLD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [VC_NUM-1:0]         vc_head_vld_i,
    input  logic [VC_NUM-1:0]         vc_credit_ok_i,
    input  logic [VC_NUM*QOS_W-1:0]   vc_qos_value_i,
    input  logic                      sa_global_grt_i,
    output logic                      sa_local_vld_o,
    output logic [VC_ID_W-1:0]        sa_local_vc_id_o,
    output logic [VC_NUM-1:0]         sa_local_vc_oh_o,
    output logic [QOS_W-1:0]          sa_local_qos_value_o
);

    sa_local_state_e                state;
    logic [VC_ID_W-1:0]             held_vc;
    logic [VC_ID_W-1:0]             rr_ptr;
    logic [VC_NUM-1:0][AGE_W-1:0]   age;

    logic [VC_NUM-1:0]              elig;
    logic [VC_NUM-1:0][QOS_W-1:0]   eq;
    logic                           hold_ok;
    logic                           grant;

    logic                           pick_vld;
    logic [VC_NUM-1:0]              pick_oh;
    logic [VC_ID_W-1:0]             pick_id;

    assign elig = vc_head_vld_i & vc_credit_ok_i;

    always_comb begin
        eq = '0;
        for (int unsigned v = 0; v < VC_NUM; v++) begin
            eq[v] = (age[v] == AGE_W'(AGE_THRESHOLD)) ? '1
                                                      : vc_qos_value_i[v*QOS_W +: QOS_W];
        end
    end

    sa_local_vc_pick #(
        .VC_NUM  (VC_NUM),
        .VC_ID_W (VC_ID_W),
        .QOS_W   (QOS_W)
    ) u_pick (
        .elig     (elig),
        .eq       (eq),
        .rr_ptr   (rr_ptr),
        .pick_vld (pick_vld),
        .pick_oh  (pick_oh),
        .pick_id  (pick_id)
    );

    // A hold is honoured only while its VC is still eligible. Otherwise the
    // fresh pick shows through in the same cycle.
    assign hold_ok = (state == HOLD) && elig[held_vc];

    always_comb begin
        sa_local_vld_o       = 1'b0;
        sa_local_vc_id_o     = '0;
        sa_local_vc_oh_o     = '0;
        sa_local_qos_value_o = '0;
        if (!rst) begin
            if (hold_ok) begin
                sa_local_vld_o   = 1'b1;
                sa_local_vc_id_o = held_vc;
                sa_local_vc_oh_o = VC_NUM'(1) << held_vc;
            end else if (pick_vld) begin
                sa_local_vld_o   = 1'b1;
                sa_local_vc_id_o = pick_id;
                sa_local_vc_oh_o = pick_oh;
            end
            if (sa_local_vld_o) begin
                sa_local_qos_value_o = eq[sa_local_vc_id_o];
            end
        end
    end

    // The outputs are already zero during reset, so a grant cannot apply then.
    assign grant = sa_local_vld_o && sa_global_grt_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            held_vc <= '0;
            age     <= '0;
        end else begin
            if (grant) begin
                rr_ptr <= (sa_local_vc_id_o == VC_ID_W'(VC_NUM - 1)) ? '0
                                                                     : sa_local_vc_id_o + 1'b1;
            end

            for (int unsigned v = 0; v < VC_NUM; v++) begin
                if (!elig[v]) begin
                    age[v] <= '0;
                end else if (grant && sa_local_vc_oh_o[v]) begin
                    age[v] <= '0;
                end else if (age[v] != AGE_W'(AGE_THRESHOLD)) begin
                    age[v] <= age[v] + 1'b1;
                end
            end

            if (hold_ok) begin
                state <= grant ? IDLE : HOLD;
            end else if (pick_vld && !grant) begin
                state   <= HOLD;
                held_vc <= pick_id;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_sa_local.sv
// Self-checking bench for sa_local. A high-level reference model predicts the
// presented VC every cycle. Directed vectors also carry hand-computed
// expectations that pin the model.
module tb_sa_local;
    import rvh_noc_pkg::*;

    localparam int unsigned N   = 6;
    localparam int unsigned IW  = 3;
    localparam int unsigned QW  = 4;
    localparam int unsigned THR = 15;

    logic            clk    = 1'b0;
    logic            rst    = 1'b1;
    logic [N-1:0]    head   = '0;
    logic [N-1:0]    credit = '0;
    logic [N*QW-1:0] qos    = '0;
    logic            grt    = 1'b0;
    logic            o_vld;
    logic [IW-1:0]   o_id;
    logic [N-1:0]    o_oh;
    logic [QW-1:0]   o_qos;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    sa_local #(
        .VC_NUM        (N),
        .VC_ID_W       (IW),
        .QOS_W         (QW),
        .AGE_THRESHOLD (THR)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .vc_head_vld_i        (head),
        .vc_credit_ok_i       (credit),
        .vc_qos_value_i       (qos),
        .sa_global_grt_i      (grt),
        .sa_local_vld_o       (o_vld),
        .sa_local_vc_id_o     (o_id),
        .sa_local_vc_oh_o     (o_oh),
        .sa_local_qos_value_o (o_qos)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_age[N];
    int unsigned m_rr   = 0;
    bit          m_hold = 1'b0;
    int unsigned m_held = 0;

    initial for (int i = 0; i < N; i++) m_age[i] = 0;

    function automatic void model_out(output bit vld, output int unsigned id, output int unsigned q);
        bit          el[N];
        int unsigned e[N];
        int unsigned best;
        bit          any;
        vld = 1'b0; id = 0; q = 0;
        if (rst) return;
        for (int v = 0; v < N; v++) begin
            el[v] = head[v] && credit[v];
            e[v]  = (m_age[v] == THR) ? ((1 << QW) - 1) : int'(qos[v*QW +: QW]);
        end
        if (m_hold && el[m_held]) begin
            vld = 1'b1; id = m_held; q = e[m_held];
            return;
        end
        best = 0; any = 1'b0;
        for (int v = 0; v < N; v++) begin
            if (el[v] && (!any || e[v] > best)) begin
                best = e[v]; any = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            int unsigned v;
            v = (m_rr + k) % N;
            if (el[v] && e[v] == best) begin
                vld = 1'b1; id = v; q = e[v];
                return;
            end
        end
    endfunction

    always @(posedge clk) begin
        bit          v_vld;
        int unsigned v_id, v_q;
        bit          ok, g;
        model_out(v_vld, v_id, v_q);
        if (rst) begin
            m_rr = 0; m_hold = 1'b0; m_held = 0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
        end else begin
            ok = m_hold && head[m_held] && credit[m_held];
            g  = v_vld && grt;
            for (int i = 0; i < N; i++) begin
                if (!(head[i] && credit[i])) m_age[i] = 0;
                else if (g && v_id == i) m_age[i] = 0;
                else if (m_age[i] < THR) m_age[i] = m_age[i] + 1;
            end
            if (g) m_rr = (v_id + 1) % N;
            if (ok) m_hold = !g;
            else if (v_vld && !g) begin m_hold = 1'b1; m_held = v_id; end
            else m_hold = 1'b0;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        bit          v_vld;
        int unsigned v_id, v_q;
        model_out(v_vld, v_id, v_q);
        check("m_vld", o_vld, v_vld);
        check("m_id",  o_id,  v_id);
        check("m_oh",  o_oh,  v_vld ? (longint'(1) << v_id) : 0);
        check("m_qos", o_qos, v_q);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic setq(input int v, input int unsigned val);
        qos[v*QW +: QW] = QW'(val);
    endtask

    int unsigned exp_ids[4] = '{0, 1, 2, 0};

    initial begin
        tick(); tick();
        at_neg();
        check("rst_vld", o_vld, 0);
        check("rst_qos", o_qos, 0);
        tick();
        rst = 1'b0; credit = '1;

        // 1: highest QoS wins; grant moves rr_ptr past the winner
        head = 6'b010100; setq(2, 3); setq(4, 7); grt = 1'b1;
        at_neg();
        check("t1_vld", o_vld, 1);
        check("t1_id", o_id, 4);
        check("t1_qos", o_qos, 7);
        check("t1_oh", o_oh, 6'b010000);
        tick();
        check("t1_rr", dut.rr_ptr, 5);
        check("t1_state", dut.state, IDLE);
        head = '0; grt = 1'b0; qos = '0;
        tick();

        // a grant while nothing is presented is ignored
        grt = 1'b1;
        at_neg();
        check("nv_vld", o_vld, 0);
        tick();
        check("nv_rr", dut.rr_ptr, 5);

        // 2: equal QoS round-robin with wrap
        head = 6'b000111; setq(0, 5); setq(1, 5); setq(2, 5);
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check("t2_id", o_id, exp_ids[k]);
            tick();
        end
        check("t2_rr", dut.rr_ptr, 1);
        head = '0; grt = 1'b0; qos = '0;
        tick();

        // 3: pick is held against a later higher-QoS VC
        head = 6'b000010; setq(1, 2);
        at_neg();
        check("t3_id0", o_id, 1);
        tick();
        check("t3_state", dut.state, HOLD);
        tick();
        head = 6'b001010; setq(3, 9);
        at_neg();
        check("t3_id", o_id, 1);
        check("t3_qos", o_qos, 2);
        tick();

        // 4: held VC loses credit -> fresh pick in the same cycle
        credit[1] = 1'b0;
        at_neg();
        check("t4_vld", o_vld, 1);
        check("t4_id", o_id, 3);
        check("t4_qos", o_qos, 9);
        tick();
        grt = 1'b1;
        at_neg();
        check("t4_gid", o_id, 3);
        tick();
        check("t4_rr", dut.rr_ptr, 4);
        head = '0; grt = 1'b0; credit = '1; qos = '0;
        tick();

        // 5: starved VC0 ages to max QoS and wins
        head = 6'b100001; setq(0, 1); setq(5, 8); grt = 1'b1;
        for (int k = 0; k < 15; k++) begin
            at_neg();
            check("t5_pre_id", o_id, 5);
            check("t5_pre_qos", o_qos, 8);
            tick();
        end
        at_neg();
        check("t5_id", o_id, 0);
        check("t5_qos", o_qos, 15);
        tick();
        check("t5_age0", dut.age[0], 0);
        at_neg();
        check("t5_post_id", o_id, 5);
        tick();
        head = '0; grt = 1'b0; qos = '0;
        tick();

        // 6: reset mid-HOLD with grant asserted
        head = 6'b000100; setq(2, 4); grt = 1'b1;
        at_neg();
        tick();
        grt = 1'b0;
        at_neg();
        tick();
        check("t6_hold", dut.state, HOLD);
        check("t6_rr3", dut.rr_ptr, 3);
        rst = 1'b1; grt = 1'b1;
        at_neg();
        check("t6_vld", o_vld, 0);
        check("t6_id", o_id, 0);
        check("t6_oh", o_oh, 0);
        check("t6_qos", o_qos, 0);
        tick();
        rst = 1'b0; grt = 1'b0;
        check("t6_rr", dut.rr_ptr, 0);
        check("t6_state", dut.state, IDLE);
        check("t6_age2", dut.age[2], 0);
        head = '1; for (int v = 0; v < N; v++) setq(v, 5);
        at_neg();
        check("t6_id0", o_id, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
